// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (diff = a - b - bin), one bit per clock, LSB first.
// Optional signed overflow flag enabled by defining SIGNED_OVF_EN.
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out,
   output logic             ovf
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           state_q;
   logic [WIDTH-1:0] sa_q, sb_q, sd_q, diff_q;
   logic [CW-1:0]    cnt_q;
   logic             br_q, bout_q, busy_q, done_q;
   logic             bit_d, br_d;

   // Full-subtractor cell on the current LSBs
   assign bit_d = sa_q[0] ^ sb_q[0] ^ br_q;
   assign br_d  = (~sa_q[0] & sb_q[0]) | (~sa_q[0] & br_q) | (sb_q[0] & br_q);

`ifdef SIGNED_OVF_EN
   logic amsb_q, bmsb_q, ovf_q;
   assign ovf = ovf_q;
`else
   assign ovf = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         sa_q    <= '0;
         sb_q    <= '0;
         sd_q    <= '0;
         diff_q  <= '0;
         cnt_q   <= '0;
         br_q    <= 1'b0;
         bout_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef SIGNED_OVF_EN
         amsb_q  <= 1'b0;
         bmsb_q  <= 1'b0;
         ovf_q   <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE, S_DONE: begin
               if (start) begin
                  sa_q    <= a;
                  sb_q    <= b;
                  br_q    <= bin;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= S_RUN;
`ifdef SIGNED_OVF_EN
                  amsb_q  <= a[WIDTH-1];
                  bmsb_q  <= b[WIDTH-1];
`endif
               end else begin
                  state_q <= S_IDLE;
               end
            end
            S_RUN: begin
               sd_q  <= {bit_d, sd_q[WIDTH-1:1]};
               sa_q  <= sa_q >> 1;
               sb_q  <= sb_q >> 1;
               br_q  <= br_d;
               cnt_q <= cnt_q + 1'b1;
               // Results are only published on the final bit, never partially
               if (cnt_q == LAST) begin
                  diff_q  <= {bit_d, sd_q[WIDTH-1:1]};
                  bout_q  <= br_d;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= S_DONE;
`ifdef SIGNED_OVF_EN
                  ovf_q   <= (amsb_q ^ bmsb_q) & (amsb_q ^ bit_d);
`endif
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign diff       = diff_q;
   assign borrow_out = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8): directed table, corner sequences,
// and random back-to-back ops against an arithmetic reference model.
module tb_serial_subtractor;

   localparam int W = 8;
`ifdef SIGNED_OVF_EN
   localparam bit OVF_EN = 1'b1;
`else
   localparam bit OVF_EN = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst_n, start, bin;
   logic [W-1:0] a, b;
   logic         busy, done, borrow_out, ovf;
   logic [W-1:0] diff;

   int checks = 0;
   int errs   = 0;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
      .busy(busy), .done(done), .diff(diff), .borrow_out(borrow_out), .ovf(ovf)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] a, b;
      logic       bin;
      logic [7:0] diff;
      logic       bo;
      logic       sovf;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference: plain 9-bit unsigned and integer signed arithmetic
   function automatic void model(input logic [7:0] x, input logic [7:0] y, input logic c,
                                 output logic [7:0] d, output logic bo, output logic ov);
      logic [8:0] r;
      int s;
      r  = {1'b0, x} - {1'b0, y} - {8'b0, c};
      d  = r[7:0];
      bo = r[8];
      s  = int'($signed(x)) - int'($signed(y)) - int'(c);
      ov = OVF_EN && (s > 127 || s < -128);
   endfunction

   // Accept at E0, then E1..E8; returns positioned in the done cycle
   task automatic do_op(input logic [7:0] ta, input logic [7:0] tb_, input logic tbin,
                        input logic [7:0] ed, input logic ebo, input logic eov,
                        input string nm);
      logic bad;
      logic [7:0] held;
      a = ta; b = tb_; bin = tbin; start = 1'b1;
      step();
      start = 1'b0;
      a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
      held = diff;
      bad  = 1'b0;
      if (busy !== 1'b1 || done !== 1'b0) bad = 1'b1;
      for (int i = 1; i < W; i++) begin
         step();
         if (done !== 1'b0 || busy !== 1'b1 || diff !== held) bad = 1'b1;
      end
      chk({nm, "_run"}, 32'(bad), 32'd0);
      step();
      chk({nm, "_done"}, {30'd0, done, busy}, 32'h2);
      chk({nm, "_res"}, {22'd0, ovf, borrow_out, diff}, {22'd0, eov, ebo, ed});
   endtask

   always @(negedge clk) begin
      if (rst_n === 1'b1 && busy === 1'b1 && done === 1'b1) begin
         errs++;
         $display("FAIL busy_done_overlap: got busy=1 done=1 required not both");
      end
   end

   vec_t tbl[7];

   initial begin
      logic [7:0] ra, rb, ed;
      logic       rc, ebo, eov;
      int         n;

      tbl[0] = '{8'h5A, 8'h23, 1'b0, 8'h37, 1'b0, 1'b0};
      tbl[1] = '{8'h10, 8'h20, 1'b0, 8'hF0, 1'b1, 1'b0};
      tbl[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
      tbl[3] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
      tbl[4] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
      tbl[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
      tbl[6] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};

      // Reset from power-up state
      rst_n = 1'b0; start = 1'b0; a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
      step(); step();
      chk("reset0", {27'd0, busy, done, borrow_out, ovf, 1'b0}, 32'd0);
      chk("reset0_diff", 32'(diff), 32'd0);
      rst_n = 1'b1;
      step();

      // Directed table, back-to-back
      foreach (tbl[i])
         do_op(tbl[i].a, tbl[i].b, tbl[i].bin, tbl[i].diff, tbl[i].bo,
               OVF_EN & tbl[i].sovf, $sformatf("vec%0d", i));
      step();
      chk("idle_after_done", {30'd0, busy, done}, 32'd0);
      chk("diff_held", 32'(diff), 32'h80);

      // start and operand changes during RUN are ignored
      a = 8'h5A; b = 8'h23; bin = 1'b0; start = 1'b1;
      step();
      start = 1'b0;
      step(); step(); step();
      start = 1'b1; a = 8'hFF; b = 8'h11; bin = 1'b1;
      step();
      start = 1'b0;
      step(); step(); step(); step();
      chk("midrun_done", {30'd0, done, busy}, 32'h2);
      chk("midrun_res", {23'd0, borrow_out, diff}, {23'd0, 1'b0, 8'h37});
      step();
      step();
      chk("midrun_noqueue", {30'd0, busy, done}, 32'd0);

      // Reset at bit 4 aborts the op
      a = 8'h10; b = 8'h20; bin = 1'b0; start = 1'b1;
      step();
      start = 1'b0;
      step(); step(); step(); step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      chk("abort_rst", {27'd0, busy, done, borrow_out, ovf, 1'b0}, 32'd0);
      chk("abort_diff", 32'(diff), 32'd0);
      n = 0;
      for (int i = 0; i < 12; i++) begin
         step();
         if (done !== 1'b0 || busy !== 1'b0) n++;
      end
      chk("abort_no_done", 32'(n), 32'd0);

      // start held through DONE: next done 9 cycles later
      do_op(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, OVF_EN, "pre_b2b");
      a = 8'h00; b = 8'h00; bin = 1'b1; start = 1'b1;
      n = 0;
      do begin
         step();
         n++;
      end while (done !== 1'b1 && n < 20);
      start = 1'b0;
      chk("b2b_spacing", 32'(n), 32'd9);
      chk("b2b_res", {22'd0, ovf, borrow_out, diff}, {22'd0, 1'b0, 1'b1, 8'hFF});
      step();
      step();

      // Random back-to-back ops against the model
      for (int i = 0; i < 3000; i++) begin
         ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
         if (i % 500 == 0) begin ra = 8'h80; rb = 8'h7F; end
         model(ra, rb, rc, ed, ebo, eov);
         do_op(ra, rb, rc, ed, ebo, eov, $sformatf("rnd%0d", i));
      end
      start = 1'b0;
      step();

      // Reset from a random mid-run state
      a = 8'($urandom); b = 8'($urandom); start = 1'b1;
      step();
      start = 1'b0;
      step(); step();
      rst_n = 1'b0;
      step(); step();
      chk("reset_mid", {27'd0, busy, done, borrow_out, ovf, 1'b0}, 32'd0);
      chk("reset_mid_diff", 32'(diff), 32'd0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
